// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad lock controller.
package keypad_pkg;

   localparam int unsigned KEY_W      = 4;
   localparam int unsigned DIG_W      = 16;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned NUM_DIGITS = 4;

   localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;
   localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hA;
   localparam logic [KEY_W-1:0] KEY_BKSP      = 4'hB;
   localparam logic [KEY_W-1:0] KEY_CLR       = 4'hC;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_CHECK   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // One accepted key: single-cycle strobe plus the code that was held.
   typedef struct packed {
      logic             evt;
      logic [KEY_W-1:0] code;
   } key_evt_t;

   function automatic logic is_digit(input logic [KEY_W-1:0] k);
      return (k <= KEY_DIGIT_MAX);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Input registration, debounce and one-shot key event generation.
module key_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] i_key,
   input  logic             i_pressed,
   output key_evt_t         o_kev
);

   localparam int unsigned   CW       = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_key_d;
   logic             r_pressed;
   logic             r_pressed_d;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_rel;
   logic             r_armed;
   logic             r_fresh;
   key_evt_t         r_kev;
   logic             w_stable;

   // A fresh press never counts as stable on its first registered cycle.
   assign w_stable = r_pressed && r_pressed_d && (r_key == r_key_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key       <= '0;
         r_key_d     <= '0;
         r_pressed   <= 1'b0;
         r_pressed_d <= 1'b0;
         r_cnt       <= '0;
         r_rel       <= '0;
         r_armed     <= 1'b0;
         r_fresh     <= 1'b1;
         r_kev       <= '0;
      end else begin
         r_key       <= i_key;
         r_pressed   <= i_pressed;
         r_key_d     <= r_key;
         r_pressed_d <= r_pressed;
         r_fresh     <= 1'b0;
         r_kev.evt   <= 1'b0;

         if (w_stable) begin
            if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end

         if (r_pressed)              r_rel <= '0;
         else if (r_rel != CNT_LAST) r_rel <= r_rel + CW'(1);

         // Arm after reset or a full release; fire once per armed press.
         if (r_fresh || (!r_pressed && (r_rel == CNT_LAST))) begin
            r_armed <= 1'b1;
         end else if (w_stable && r_armed && (r_cnt == CNT_LAST)) begin
            r_armed    <= 1'b0;
            r_kev.evt  <= 1'b1;
            r_kev.code <= r_key;
         end
      end
   end

   assign o_kev = r_kev;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: digit entry/editing, password check, timed open and lockout.
module keypad_lock_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned OPEN_CYC     = 200,
   parameter int unsigned LOCKOUT_CYC  = 1000,
   parameter int unsigned MAX_TRIES    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key,
   input  logic             pressed,
   input  logic [DIG_W-1:0] pwd,
   output logic [DIG_W-1:0] digits,
   output logic [CNT_W-1:0] count,
   output logic             key_evt,
   output logic             unlocked,
   output logic             locked_out,
   output logic             err
);

   localparam int unsigned    DWELL_MAX  = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
   localparam int unsigned    TW         = (DWELL_MAX < 2) ? 1 : $clog2(DWELL_MAX);
   localparam int unsigned    TRW        = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0]  OPEN_LAST  = TW'(OPEN_CYC - 1);
   localparam logic [TW-1:0]  LOCK_LAST  = TW'(LOCKOUT_CYC - 1);
   localparam logic [TRW-1:0] TRIES_LAST = TRW'(MAX_TRIES - 1);

   key_evt_t         w_kev;
   state_t           r_state,  w_state_nx;
   logic [DIG_W-1:0] r_digits, w_digits_nx;
   logic [CNT_W-1:0] r_count,  w_count_nx;
   logic [TRW-1:0]   r_tries,  w_tries_nx;
   logic [TW-1:0]    r_timer,  w_timer_nx;
   logic             r_err,    w_err_nx;
   logic             r_unlocked;
   logic             r_locked_out;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .i_key     (key),
      .i_pressed (pressed),
      .o_kev     (w_kev)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_ENTRY;
         r_digits     <= '0;
         r_count      <= '0;
         r_tries      <= '0;
         r_timer      <= '0;
         r_err        <= 1'b0;
         r_unlocked   <= 1'b0;
         r_locked_out <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_digits     <= w_digits_nx;
         r_count      <= w_count_nx;
         r_tries      <= w_tries_nx;
         r_timer      <= w_timer_nx;
         r_err        <= w_err_nx;
         r_unlocked   <= (w_state_nx == ST_OPEN);
         r_locked_out <= (w_state_nx == ST_LOCKOUT);
      end
   end

   // Timer defaults to zero so every state entry starts a fresh dwell.
   always_comb begin
      w_state_nx  = r_state;
      w_digits_nx = r_digits;
      w_count_nx  = r_count;
      w_tries_nx  = r_tries;
      w_timer_nx  = '0;
      w_err_nx    = 1'b0;

      case (r_state)
         ST_ENTRY: begin
            if (w_kev.evt) begin
               if (is_digit(w_kev.code)) begin
                  if (r_count != CNT_FULL) begin
                     w_digits_nx = {r_digits[DIG_W-KEY_W-1:0], w_kev.code};
                     w_count_nx  = r_count + CNT_W'(1);
                  end
               end else begin
                  case (w_kev.code)
                     KEY_BKSP: begin
                        if (r_count != '0) begin
                           w_digits_nx = {{KEY_W{1'b0}}, r_digits[DIG_W-1:KEY_W]};
                           w_count_nx  = r_count - CNT_W'(1);
                        end
                     end
                     KEY_CLR: begin
                        w_digits_nx = '0;
                        w_count_nx  = '0;
                     end
                     KEY_ENTER: begin
                        if (r_count == CNT_FULL) w_state_nx = ST_CHECK;
                        else                     w_err_nx   = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_CHECK: begin
            w_digits_nx = '0;
            w_count_nx  = '0;
            if (r_digits == pwd) begin
               w_tries_nx = '0;
               w_state_nx = ST_OPEN;
            end else begin
               w_err_nx   = 1'b1;
               w_tries_nx = r_tries + TRW'(1);
               w_state_nx = (r_tries == TRIES_LAST) ? ST_LOCKOUT : ST_ENTRY;
            end
         end
         ST_OPEN: begin
            if ((w_kev.evt && (w_kev.code == KEY_CLR)) || (r_timer == OPEN_LAST)) begin
               w_state_nx = ST_ENTRY;
            end else begin
               w_timer_nx = r_timer + TW'(1);
            end
         end
         ST_LOCKOUT: begin
            if (r_timer == LOCK_LAST) begin
               w_tries_nx = '0;
               w_state_nx = ST_ENTRY;
            end else begin
               w_timer_nx = r_timer + TW'(1);
            end
         end
         default: w_state_nx = ST_ENTRY;
      endcase
   end

   assign digits     = r_digits;
   assign count      = r_count;
   assign key_evt    = w_kev.evt;
   assign unlocked   = r_unlocked;
   assign locked_out = r_locked_out;
   assign err        = r_err;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboard bench for keypad_lock_ctrl: stimulus queues expected events, a monitor pops them.
module tb_keypad_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key;
   logic        pressed;
   logic [15:0] pwd;
   logic [15:0] digits;
   logic [2:0]  count;
   logic        key_evt;
   logic        unlocked;
   logic        locked_out;
   logic        err;

   always #5 clk = ~clk;

   keypad_lock_ctrl #(
      .DEBOUNCE_CYC (4),
      .OPEN_CYC     (200),
      .LOCKOUT_CYC  (1000),
      .MAX_TRIES    (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .pressed    (pressed),
      .pwd        (pwd),
      .digits     (digits),
      .count      (count),
      .key_evt    (key_evt),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .err        (err)
   );

   typedef enum int {K_KEY, K_RST, K_ERR, K_URISE, K_UFALL, K_LRISE, K_LFALL} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] val;
      bit          any;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] pl_key(input logic unl, input logic lo,
                                          input logic [2:0] c, input logic [15:0] d);
      return {11'd0, unl, lo, c, d};
   endfunction

   function automatic logic [31:0] pl_cd(input logic [2:0] c, input logic [15:0] d);
      return {13'd0, c, d};
   endfunction

   task automatic push(input kind_t k, input logic [31:0] v, input bit any);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.any  = any;
      q.push_back(e);
   endtask

   task automatic check(input kind_t k, input logic [31:0] act);
      exp_t e;
      n_tests++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: got 0x%08h, required no event", k.name(), act);
      end else begin
         e = q.pop_front();
         if (e.kind != k || (!e.any && e.val !== act)) begin
            n_fail++;
            $display("FAIL %s: got %s 0x%08h, required %s 0x%08h", e.kind.name(),
                     k.name(), act, e.kind.name(), e.val);
         end
      end
   endtask

   // Monitor: rst seen at each active edge, outputs sampled on the falling edge.
   logic rst_edge = 1'b0;
   initial forever begin
      @(posedge clk);
      rst_edge = rst;
   end

   initial begin
      int cyc = 0;
      int u_rise = 0;
      int l_rise = 0;
      bit key_pend = 1'b0;
      bit rst_q = 1'b0;
      bit unl_q = 1'b0;
      bit lo_q = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (key_pend) check(K_KEY, pl_key(unlocked, locked_out, count, digits));
         key_pend = 1'b0;
         if (rst_edge && !rst_q)
            check(K_RST, {9'd0, key_evt, err, unlocked, locked_out, count, digits});
         rst_q = rst_edge;
         if (err === 1'b1) check(K_ERR, pl_cd(count, digits));
         if (unlocked === 1'b1 && !unl_q) begin
            check(K_URISE, pl_cd(count, digits));
            u_rise = cyc;
         end
         if (unlocked === 1'b0 && unl_q) check(K_UFALL, 32'(cyc - u_rise));
         if (locked_out === 1'b1 && !lo_q) begin
            check(K_LRISE, pl_cd(count, digits));
            l_rise = cyc;
         end
         if (locked_out === 1'b0 && lo_q) check(K_LFALL, 32'(cyc - l_rise));
         unl_q = (unlocked === 1'b1);
         lo_q  = (locked_out === 1'b1);
         if (key_evt === 1'b1) key_pend = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [3:0] k, input int hold);
      tick(1);
      key     = k;
      pressed = 1'b1;
      tick(hold);
      pressed = 1'b0;
      tick(6);
   endtask

   // Key accepted in ENTRY (or ignored): expected count/digits one cycle after key_evt.
   task automatic key_in(input logic [3:0] k, input logic [2:0] c, input logic [15:0] d);
      push(K_KEY, pl_key(1'b0, 1'b0, c, d), 1'b0);
      press(k, 6);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q.size() == 0) return;
         tick(1);
      end
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending events, required 0", q.size());
      q.delete();
   endtask

   task automatic enter_wrong(input bit last);
      key_in(4'h0, 3'd1, 16'h0000);
      key_in(4'h0, 3'd2, 16'h0000);
      key_in(4'h0, 3'd3, 16'h0000);
      key_in(4'h0, 3'd4, 16'h0000);
      push(K_KEY, pl_key(1'b0, 1'b0, 3'd4, 16'h0000), 1'b0);
      push(K_ERR, pl_cd(3'd0, 16'h0000), 1'b0);
      if (last) push(K_LRISE, pl_cd(3'd0, 16'h0000), 1'b0);
      press(4'hA, 6);
   endtask

   task automatic enter_right();
      key_in(4'h1, 3'd1, 16'h0001);
      key_in(4'h2, 3'd2, 16'h0012);
      key_in(4'h3, 3'd3, 16'h0123);
      key_in(4'h4, 3'd4, 16'h1234);
      push(K_KEY, pl_key(1'b0, 1'b0, 3'd4, 16'h1234), 1'b0);
      push(K_URISE, pl_cd(3'd0, 16'h0000), 1'b0);
      press(4'hA, 6);
   endtask

   initial begin
      rst     = 1'b1;
      key     = 4'h0;
      pressed = 1'b0;
      pwd     = 16'h1234;
      push(K_RST, 32'd0, 1'b0);
      tick(3);
      rst = 1'b0;
      tick(2);
      wait_drain(10);

      // editing: digits, backspace, clear, no-op keys
      key_in(4'h1, 3'd1, 16'h0001);
      key_in(4'h2, 3'd2, 16'h0012);
      key_in(4'hB, 3'd1, 16'h0001);
      key_in(4'h9, 3'd2, 16'h0019);
      key_in(4'hC, 3'd0, 16'h0000);
      key_in(4'hB, 3'd0, 16'h0000);
      key_in(4'hD, 3'd0, 16'h0000);
      wait_drain(50);

      // enter with three digits, then a fifth digit
      key_in(4'h1, 3'd1, 16'h0001);
      key_in(4'h2, 3'd2, 16'h0012);
      key_in(4'h3, 3'd3, 16'h0123);
      push(K_KEY, pl_key(1'b0, 1'b0, 3'd3, 16'h0123), 1'b0);
      push(K_ERR, pl_cd(3'd3, 16'h0123), 1'b0);
      press(4'hA, 6);
      key_in(4'h4, 3'd4, 16'h1234);
      key_in(4'h5, 3'd4, 16'h1234);
      key_in(4'hC, 3'd0, 16'h0000);
      wait_drain(50);

      // correct code, open times out after 200 cycles
      enter_right();
      push(K_UFALL, 32'd200, 1'b0);
      wait_drain(400);

      // bounce then long hold
      key = 4'h3;
      for (int i = 0; i < 5; i++) begin
         pressed = 1'b1;
         tick(2);
         pressed = 1'b0;
         tick(2);
      end
      tick(10);
      push(K_KEY, pl_key(1'b0, 1'b0, 3'd1, 16'h0003), 1'b0);
      press(4'h3, 100);
      key_in(4'hC, 3'd0, 16'h0000);
      wait_drain(50);

      // three failures, lockout ignoring keys for 1000 cycles
      enter_wrong(1'b0);
      enter_wrong(1'b0);
      enter_wrong(1'b1);
      push(K_KEY, pl_key(1'b0, 1'b1, 3'd0, 16'h0000), 1'b0);
      press(4'h5, 6);
      push(K_KEY, pl_key(1'b0, 1'b1, 3'd0, 16'h0000), 1'b0);
      press(4'hA, 6);
      push(K_LFALL, 32'd1000, 1'b0);
      wait_drain(1200);

      // tries restart from zero; then open and close early with C
      enter_wrong(1'b0);
      enter_wrong(1'b0);
      enter_right();
      push(K_KEY, pl_key(1'b1, 1'b0, 3'd0, 16'h0000), 1'b0);
      press(4'h7, 6);
      push(K_KEY, pl_key(1'b0, 1'b0, 3'd0, 16'h0000), 1'b0);
      push(K_UFALL, 32'd0, 1'b1);
      press(4'hC, 6);
      wait_drain(100);

      // reset in the middle of lockout
      enter_wrong(1'b0);
      enter_wrong(1'b0);
      enter_wrong(1'b1);
      wait_drain(200);
      tick(498);
      push(K_RST, 32'd0, 1'b0);
      push(K_LFALL, 32'd0, 1'b1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      key_in(4'h7, 3'd1, 16'h0007);
      wait_drain(50);

      tick(20);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_events: got %0d pending, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
